// File: rtl/lbp_hist_engine.sv
// rtl/lbp_hist_engine.sv - per-cell 256-bin LBP histogram builder with saturating bins
module lbp_hist_engine #(
  parameter int IMG_LOG2      = 6,
  parameter int MAX_GRID_LOG2 = 4,
  parameter int SLOT_W        = 5,
  parameter int CNT_W         = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [2:0]                        grid_log2x,
  input  logic [2:0]                        grid_log2y,
  input  logic [SLOT_W-1:0]                 slot,
  output logic                              lbp_ren,
  output logic [2*IMG_LOG2-1:0]             lbp_addr,
  input  logic [7:0]                        lbp_rdata,
  output logic                              hist_ren,
  output logic                              hist_wen,
  output logic [SLOT_W+2*MAX_GRID_LOG2+7:0] hist_addr,
  output logic [CNT_W-1:0]                  hist_wdata,
  input  logic [CNT_W-1:0]                  hist_rdata,
  output logic                              busy,
  output logic                              done,
  output logic                              sat
);

  localparam int G_W = MAX_GRID_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    PIX_RD  = 3'd2,
    HIST_RD = 3'd3,
    HIST_WR = 3'd4,
    DONE_S  = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          gx_q, gy_q, gx_nxt, gy_nxt;
  logic [SLOT_W-1:0]   slot_q, slot_nxt;
  logic [G_W-1:0]      cx, cy, cx_nxt, cy_nxt;
  logic [IMG_LOG2-1:0] px, py, px_nxt, py_nxt;
  logic [7:0]          bin_q, bin_nxt;
  logic                sat_nxt;
  logic [IMG_LOG2-1:0] w_last, h_last;
  logic [G_W-1:0]      cx_last, cy_last;

  function automatic logic [2:0] clamp_grid(input logic [2:0] g);
    int v;
    v = int'(g);
    if (v > MAX_GRID_LOG2) v = MAX_GRID_LOG2;
    if (v > IMG_LOG2) v = IMG_LOG2;
    return 3'(v);
  endfunction

  // Image coordinate of a pixel: cell index scaled by the cell size plus offset.
  function automatic logic [IMG_LOG2-1:0] coord(input logic [G_W-1:0] c,
                                                input logic [2:0] g,
                                                input logic [IMG_LOG2-1:0] p);
    int v;
    v = (int'(c) << (IMG_LOG2 - int'(g))) + int'(p);
    return IMG_LOG2'(v);
  endfunction

  always_comb begin
    w_last  = IMG_LOG2'((1 << (IMG_LOG2 - int'(gx_q))) - 1);
    h_last  = IMG_LOG2'((1 << (IMG_LOG2 - int'(gy_q))) - 1);
    cx_last = G_W'((1 << int'(gx_q)) - 1);
    cy_last = G_W'((1 << int'(gy_q)) - 1);
  end

  always_comb begin
    state_nxt = state;
    gx_nxt    = gx_q;
    gy_nxt    = gy_q;
    slot_nxt  = slot_q;
    cx_nxt    = cx;
    cy_nxt    = cy;
    px_nxt    = px;
    py_nxt    = py;
    bin_nxt   = bin_q;
    sat_nxt   = sat;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = CLEAR;
          gx_nxt    = clamp_grid(grid_log2x);
          gy_nxt    = clamp_grid(grid_log2y);
          slot_nxt  = slot;
          cx_nxt    = '0;
          cy_nxt    = '0;
          px_nxt    = '0;
          py_nxt    = '0;
          bin_nxt   = '0;
          sat_nxt   = 1'b0;
        end
      end
      CLEAR: begin
        bin_nxt = bin_q + 8'd1;
        if (bin_q == 8'hFF) state_nxt = PIX_RD;
      end
      PIX_RD: state_nxt = HIST_RD;
      HIST_RD: begin
        bin_nxt   = lbp_rdata;
        state_nxt = HIST_WR;
      end
      HIST_WR: begin
        if (hist_rdata == CNT_MAX) sat_nxt = 1'b1;
        bin_nxt   = '0;
        state_nxt = PIX_RD;
        if (px != w_last) begin
          px_nxt = px + 1'b1;
        end else begin
          px_nxt = '0;
          if (py != h_last) begin
            py_nxt = py + 1'b1;
          end else begin
            py_nxt    = '0;
            state_nxt = CLEAR;
            if (cx != cx_last) begin
              cx_nxt = cx + 1'b1;
            end else begin
              cx_nxt = '0;
              if (cy != cy_last) cy_nxt = cy + 1'b1;
              else state_nxt = DONE_S;
            end
          end
        end
      end
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gx_q     <= '0;
      gy_q     <= '0;
      slot_q   <= '0;
      cx       <= '0;
      cy       <= '0;
      px       <= '0;
      py       <= '0;
      bin_q    <= '0;
      sat      <= 1'b0;
      lbp_ren  <= 1'b0;
      lbp_addr <= '0;
      hist_ren <= 1'b0;
      hist_wen <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gx_q     <= gx_nxt;
      gy_q     <= gy_nxt;
      slot_q   <= slot_nxt;
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      px       <= px_nxt;
      py       <= py_nxt;
      bin_q    <= bin_nxt;
      sat      <= sat_nxt;
      lbp_ren  <= (state_nxt == PIX_RD);
      lbp_addr <= {coord(cy_nxt, gy_nxt, py_nxt), coord(cx_nxt, gx_nxt, px_nxt)};
      hist_ren <= (state_nxt == HIST_RD);
      hist_wen <= (state_nxt == CLEAR) || (state_nxt == HIST_WR);
      busy     <= (state_nxt == CLEAR) || (state_nxt == PIX_RD) ||
                  (state_nxt == HIST_RD) || (state_nxt == HIST_WR);
      done     <= (state_nxt == DONE_S);
    end
  end

  // The LBP code only arrives in HIST_RD, so the bin field bypasses the latch there.
  always_comb begin
    hist_addr  = {slot_q, cy, cx, (state == HIST_RD) ? lbp_rdata : bin_q};
    hist_wdata = '0;
    if (state == HIST_WR) hist_wdata = (hist_rdata == CNT_MAX) ? CNT_MAX : hist_rdata + 1'b1;
  end

endmodule

// File: tb/tb_lbp_hist_engine.sv
// tb/tb_lbp_hist_engine.sv - model-checked bench for lbp_hist_engine at two image sizes
module tb_lbp_hist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, en_b;
  logic [2:0]  gx_a, gy_a, gx_b, gy_b;
  logic [4:0]  slot_a, slot_b;
  logic        lren_a, lren_b;
  logic [11:0] laddr_a;
  logic [5:0]  laddr_b;
  logic [7:0]  lrdata_a, lrdata_b;
  logic        hren_a, hwen_a, hren_b, hwen_b;
  logic [20:0] haddr_a, haddr_b;
  logic [7:0]  wdata_a, wdata_b, hrdata_a, hrdata_b;
  logic        busy_a, done_a, sat_a, busy_b, done_b, sat_b;

  lbp_hist_engine dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .grid_log2x(gx_a), .grid_log2y(gy_a), .slot(slot_a),
    .lbp_ren(lren_a), .lbp_addr(laddr_a), .lbp_rdata(lrdata_a),
    .hist_ren(hren_a), .hist_wen(hwen_a), .hist_addr(haddr_a), .hist_wdata(wdata_a),
    .hist_rdata(hrdata_a), .busy(busy_a), .done(done_a), .sat(sat_a)
  );

  lbp_hist_engine #(.IMG_LOG2(3)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .grid_log2x(gx_b), .grid_log2y(gy_b), .slot(slot_b),
    .lbp_ren(lren_b), .lbp_addr(laddr_b), .lbp_rdata(lrdata_b),
    .hist_ren(hren_b), .hist_wen(hwen_b), .hist_addr(haddr_b), .hist_wdata(wdata_b),
    .hist_rdata(hrdata_b), .busy(busy_b), .done(done_b), .sat(sat_b)
  );

  logic [7:0] img_a [0:4095];
  logic [7:0] img_b [0:63];
  logic [7:0] hmem_a [0:(1<<21)-1];
  logic [7:0] hmem_b [0:(1<<21)-1];

  always @(posedge clk) begin
    if (lren_a) lrdata_a <= img_a[laddr_a];
    if (hren_a) hrdata_a <= hmem_a[haddr_a];
    if (hwen_a) hmem_a[haddr_a] <= wdata_a;
    if (lren_b) lrdata_b <= img_b[laddr_b];
    if (hren_b) hrdata_b <= hmem_b[haddr_b];
    if (hwen_b) hmem_b[haddr_b] <= wdata_b;
  end

  typedef struct packed {
    logic        lren;
    logic [11:0] laddr;
    logic        hren;
    logic        hwen;
    logic [20:0] haddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        sat;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int  checks = 0;
  int  errors = 0;
  bit  act_a = 0, act_b = 0;
  int  cyc_a = 0, cyc_b = 0, done_cyc_a = 0, done_cyc_b = 0, dones_a = 0, dones_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] hadr(input int sl, input int cy, input int cx, input int b);
    return 21'((sl << 16) | (cy << 12) | (cx << 8) | b);
  endfunction

  function automatic int clampg(input int g, input int il);
    int v;
    v = g;
    if (v > 4) v = 4;
    if (v > il) v = il;
    return v;
  endfunction

  task automatic push(input bit is_b, input ev_t e);
    if (is_b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  // Expected bus activity, cycle by cycle, straight from the cell/pixel walk.
  task automatic build(input bit is_b, input int il, input int rgx, input int rgy, input int sl);
    int  gx, gy, side, w, h, row, col, code, nv;
    int  cnt[256];
    bit  sm;
    ev_t e;
    gx = clampg(rgx, il);
    gy = clampg(rgy, il);
    side = 1 << il;
    w = side >> gx;
    h = side >> gy;
    sm = 1'b0;
    for (int cy = 0; cy < (1 << gy); cy++) begin
      for (int cx = 0; cx < (1 << gx); cx++) begin
        for (int b = 0; b < 256; b++) begin
          e = '0; e.hwen = 1'b1; e.haddr = hadr(sl, cy, cx, b); e.busy = 1'b1; e.sat = sm;
          push(is_b, e);
          cnt[b] = 0;
        end
        for (int py = 0; py < h; py++) begin
          for (int px = 0; px < w; px++) begin
            row = cy * h + py;
            col = cx * w + px;
            code = is_b ? int'(img_b[row * side + col]) : int'(img_a[row * side + col]);
            e = '0; e.lren = 1'b1; e.laddr = 12'(row * side + col); e.busy = 1'b1; e.sat = sm;
            push(is_b, e);
            e = '0; e.hren = 1'b1; e.haddr = hadr(sl, cy, cx, code); e.busy = 1'b1; e.sat = sm;
            push(is_b, e);
            nv = (cnt[code] == 255) ? 255 : cnt[code] + 1;
            e.hren = 1'b0; e.hwen = 1'b1; e.wdata = 8'(nv);
            push(is_b, e);
            if (cnt[code] == 255) sm = 1'b1;
            cnt[code] = nv;
          end
        end
      end
    end
    e = '0; e.done = 1'b1; e.sat = sm;
    push(is_b, e);
    e.done = 1'b0;
    push(is_b, e);
  endtask

  task automatic cmp(input string tag, input ev_t e, input logic lren, input logic [11:0] laddr,
                     input logic hren, input logic hwen, input logic [20:0] haddr,
                     input logic [7:0] wd, input logic bz, input logic dn, input logic st);
    chk({tag, ".ctl"}, 64'({lren, hren, hwen, bz, dn, st}),
        64'({e.lren, e.hren, e.hwen, e.busy, e.done, e.sat}));
    if (e.lren) chk({tag, ".lbp_addr"}, 64'(laddr), 64'(e.laddr));
    if (e.hren || e.hwen) chk({tag, ".hist_addr"}, 64'(haddr), 64'(e.haddr));
    if (e.hwen) chk({tag, ".hist_wdata"}, 64'(wd), 64'(e.wdata));
  endtask

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (act_a && q_a.size() > 0) begin
        e = q_a.pop_front();
        cyc_a++;
        cmp("a", e, lren_a, laddr_a, hren_a, hwen_a, haddr_a, wdata_a, busy_a, done_a, sat_a);
        if (done_a) done_cyc_a = cyc_a;
      end
      if (act_b && q_b.size() > 0) begin
        e = q_b.pop_front();
        cyc_b++;
        cmp("b", e, lren_b, 12'(laddr_b), hren_b, hwen_b, haddr_b, wdata_b, busy_b, done_b, sat_b);
        if (done_b) done_cyc_b = cyc_b;
      end
      if (done_a) dones_a++;
      if (done_b) dones_b++;
    end
  end

  task automatic start_a(input int gx, input int gy, input int sl);
    act_a = 1'b0;
    @(posedge clk); #1;
    gx_a = 3'(gx); gy_a = 3'(gy); slot_a = 5'(sl); en_a = 1'b1;
    build(1'b0, 6, gx, gy, sl);
    @(posedge clk); #1;
    en_a = 1'b0; cyc_a = 0; dones_a = 0; act_a = 1'b1;
  endtask

  task automatic start_b(input int gx, input int gy, input int sl);
    act_b = 1'b0;
    @(posedge clk); #1;
    gx_b = 3'(gx); gy_b = 3'(gy); slot_b = 5'(sl); en_b = 1'b1;
    build(1'b1, 3, gx, gy, sl);
    @(posedge clk); #1;
    en_b = 1'b0; cyc_b = 0; dones_b = 0; act_b = 1'b1;
  endtask

  task automatic wait_a(input int budget);
    int n = 0;
    while (q_a.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk("a.drain", 64'(q_a.size()), 64'(0));
  endtask

  task automatic wait_b(input int budget);
    int n = 0;
    while (q_b.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk("b.drain", 64'(q_b.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    gx_a = '0; gy_a = '0; gx_b = '0; gy_b = '0; slot_a = '0; slot_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.a", 64'({lren_a, laddr_a, hren_a, hwen_a, haddr_a, wdata_a, busy_a, done_a, sat_a}), 64'(0));
    chk("reset.b", 64'({lren_b, laddr_b, hren_b, hwen_b, haddr_b, wdata_b, busy_b, done_b, sat_b}), 64'(0));
    rst = 1'b1;

    // 1x1 grid, uniform code 0x05: one bin saturates
    for (int i = 0; i < 4096; i++) img_a[i] = 8'h05;
    start_a(0, 0, 3);
    wait_a(13000);
    chk("t1.done_cycle", 64'(done_cyc_a), 64'(12545));
    chk("t1.done_count", 64'(dones_a), 64'(1));
    chk("t1.bin5", 64'(hmem_a[21'h30005]), 64'(255));
    chk("t1.bin4", 64'(hmem_a[21'h30004]), 64'(0));
    chk("t1.bin255", 64'(hmem_a[21'h300FF]), 64'(0));
    chk("t1.sat", 64'(sat_a), 64'(1));

    // 4x4 grid, code = cell index
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) img_a[r * 64 + c] = 8'((r / 16) * 4 + c / 16);
    start_a(2, 2, 0);
    wait_a(17000);
    chk("t2.done_cycle", 64'(done_cyc_a), 64'(16385));
    for (int k = 0; k < 16; k++) begin
      chk("t2.own_bin", 64'(hmem_a[hadr(0, k / 4, k % 4, k)]), 64'(255));
      chk("t2.other_bin", 64'(hmem_a[hadr(0, k / 4, k % 4, k + 1)]), 64'(0));
    end
    chk("t2.sat", 64'(sat_a), 64'(1));

    // 8x8 image, 2x1 grid, code = column
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img_b[r * 8 + c] = 8'(c);
    start_b(1, 0, 7);
    wait_b(1000);
    chk("t3.done_cycle", 64'(done_cyc_b), 64'(705));
    for (int b = 0; b < 4; b++) begin
      chk("t3.left", 64'(hmem_b[hadr(7, 0, 0, b)]), 64'(8));
      chk("t3.right", 64'(hmem_b[hadr(7, 0, 1, b + 4)]), 64'(8));
      chk("t3.left_empty", 64'(hmem_b[hadr(7, 0, 0, b + 4)]), 64'(0));
    end
    chk("t3.sat", 64'(sat_b), 64'(0));

    // grid_log2x out of range clamps to the image side
    start_b(7, 0, 9);
    wait_b(3000);
    chk("t4.done_cycle", 64'(done_cyc_b), 64'(2241));
    chk("t4.cell5", 64'(hmem_b[hadr(9, 0, 5, 5)]), 64'(8));
    chk("t4.cell3", 64'(hmem_b[hadr(9, 0, 3, 3)]), 64'(8));

    // reset pulse mid-CLEAR, then a clean restart
    start_b(0, 0, 4);
    repeat (100) @(posedge clk);
    #1;
    act_b = 1'b0;
    q_b.delete();
    #2 rst = 1'b0;
    #1;
    chk("t5.reset_outs", 64'({lren_b, laddr_b, hren_b, hwen_b, haddr_b, wdata_b, busy_b, done_b, sat_b}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5.idle", 64'({lren_b, hren_b, hwen_b, busy_b, done_b}), 64'(0));
    start_b(0, 0, 4);
    wait_b(1000);
    chk("t5.done_cycle", 64'(done_cyc_b), 64'(449));
    chk("t5.bin3", 64'(hmem_b[hadr(4, 0, 0, 3)]), 64'(8));

    // enable pulses and input changes during a run are ignored
    start_b(1, 1, 6);
    gx_b = 3'd3; slot_b = 5'd0;
    repeat (300) @(posedge clk);
    #1 en_b = 1'b1;
    @(posedge clk); #1 en_b = 1'b0;
    repeat (200) @(posedge clk);
    #1 en_b = 1'b1;
    @(posedge clk); #1 en_b = 1'b0;
    wait_b(2000);
    repeat (5) @(posedge clk);
    chk("t6.done_cycle", 64'(done_cyc_b), 64'(1217));
    chk("t6.done_count", 64'(dones_b), 64'(1));
    chk("t6.idle_busy", 64'(busy_b), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
